// File: rtl/edge_pkg.sv
// Shared encodings for the multi-channel edge detector: FSM states and edge-mode selects.
package edge_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    RISE_PEND = 2'b01,
    HIGH      = 2'b10,
    FALL_PEND = 2'b11
  } edge_state_e;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  function automatic logic rise_en(input logic [1:0] m);
    return (m == MODE_RISE) || (m == MODE_BOTH);
  endfunction

  function automatic logic fall_en(input logic [1:0] m);
    return (m == MODE_FALL) || (m == MODE_BOTH);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, debounce FSM with counter, registered rise/fall ticks.
// Debounce states and counter exist only when EDGE_DEBOUNCE_EN is defined.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       level,
  input  logic [1:0] mode,
  output logic       level_db,
  output logic       rise_tick,
  output logic       fall_tick
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("edge_chan: SYNC_STAGES must be >= 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("edge_chan: DB_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync;
  edge_state_e            state, state_nxt;
  logic                   rise_evt, fall_evt;

  // Stage boundary: asynchronous input into the synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_pipe <= '0;
    else          sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], level};
  end

  assign sync = sync_pipe[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_evt  = 1'b0;
    fall_evt  = 1'b0;
    unique case (state)
      LOW: if (sync) begin
        if (DB_CYCLES == 1) begin
          state_nxt = HIGH;
          rise_evt  = 1'b1;
        end else begin
          state_nxt = RISE_PEND;
          cnt_nxt   = CNT_ONE;
        end
      end
      RISE_PEND: begin
        if (!sync) begin
          state_nxt = LOW;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          rise_evt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: if (!sync) begin
        if (DB_CYCLES == 1) begin
          state_nxt = LOW;
          fall_evt  = 1'b1;
        end else begin
          state_nxt = FALL_PEND;
          cnt_nxt   = CNT_ONE;
        end
      end
      FALL_PEND: begin
        if (sync) begin
          state_nxt = HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          fall_evt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = LOW;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt_nxt;
  end
`else
  always_comb begin
    state_nxt = state;
    rise_evt  = 1'b0;
    fall_evt  = 1'b0;
    case (state)
      LOW: if (sync) begin
        state_nxt = HIGH;
        rise_evt  = 1'b1;
      end
      HIGH: if (!sync) begin
        state_nxt = LOW;
        fall_evt  = 1'b1;
      end
      default: state_nxt = LOW;
    endcase
  end
`endif

  // Stage boundary: FSM state and mode-gated ticks, registered on the transition edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= LOW;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      state     <= state_nxt;
      rise_tick <= rise_evt & rise_en(mode);
      fall_tick <= fall_evt & fall_en(mode);
    end
  end

  assign level_db = (state == HIGH) || (state == FALL_PEND);

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel debounced edge detector: CH independent edge_chan instances plus a registered any_tick.
// Debounce filtering is enabled by defining EDGE_DEBOUNCE_EN.
module edge_detector_multi
  import edge_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [CH-1:0]   level,
  input  logic [2*CH-1:0] mode,
  output logic [CH-1:0]   level_db,
  output logic [CH-1:0]   rise_tick,
  output logic [CH-1:0]   fall_tick,
  output logic [CH-1:0]   tick,
  output logic            any_tick
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .level     (level[i]),
      .mode      (mode[2*i +: 2]),
      .level_db  (level_db[i]),
      .rise_tick (rise_tick[i]),
      .fall_tick (fall_tick[i])
    );
  end

  assign tick = rise_tick | fall_tick;

  // Stage boundary: channel ticks reduced into one registered event flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_tick <= 1'b0;
    else          any_tick <= |tick;
  end

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi; expected latencies follow the EDGE_DEBOUNCE_EN build.
module tb_edge_detector_multi;
  localparam int CH   = 4;
  localparam int SYNC = 2;
`ifdef EDGE_DEBOUNCE_EN
  localparam int DB   = 4;
`else
  localparam int DB   = 1;
`endif
  localparam int LAT  = SYNC + DB - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] level;
  logic [7:0]    mode;
  logic [CH-1:0] level_db, rise_tick, fall_tick, tick;
  logic          any_tick;

  int n_vec  = 0;
  int n_miss = 0;
  int rk, fk, rn, fn;
  logic dbs;

  edge_detector_multi #(.CH(CH), .SYNC_STAGES(SYNC), .DB_CYCLES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .level     (level),
    .mode      (mode),
    .level_db  (level_db),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .tick      (tick),
    .any_tick  (any_tick)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise level[ch] for 'width' cycles and record tick positions over ncyc negedges.
  task automatic track_pulse(input int ch, input int width, input int ncyc,
                             output int rise_k, output int fall_k,
                             output int rise_n, output int fall_n, output logic db_seen);
    rise_k = 0; fall_k = 0; rise_n = 0; fall_n = 0; db_seen = 1'b0;
    level[ch] = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (rise_tick[ch]) begin rise_n++; rise_k = k; end
      if (fall_tick[ch]) begin fall_n++; fall_k = k; end
      if (level_db[ch]) db_seen = 1'b1;
      if (k == width) level[ch] = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0; level = 4'hF; mode = 8'hFF;
    neg(3);
    check_vec("rst_level_db", level_db, 4'h0);
    check_vec("rst_rise", rise_tick, 4'h0);
    check_vec("rst_fall", fall_tick, 4'h0);
    check_vec("rst_tick", tick, 4'h0);
    check_vec("rst_any", any_tick, 1'b0);

    reset_n = 1'b1;
    neg(LAT);
    check_vec("por_rise_early", rise_tick, 4'h0);
    neg(1);
    check_vec("por_level_db", level_db, 4'hF);
    check_vec("por_rise", rise_tick, 4'hF);
    check_vec("por_any_early", any_tick, 1'b0);
    neg(1);
    check_vec("por_rise_once", rise_tick, 4'h0);
    check_vec("por_any", any_tick, 1'b1);

    mode = 8'h00; level = 4'h0;
    neg(LAT + 4);
    check_vec("off_level_db", level_db, 4'h0);
    check_vec("off_tick", tick, 4'h0);
    check_vec("off_any", any_tick, 1'b0);

    mode = 8'h01; level = 4'h1;
    neg(LAT);
    check_vec("ch0_rise_early", rise_tick, 4'h0);
    neg(1);
    check_vec("ch0_rise", rise_tick, 4'h1);
    check_vec("ch0_level_db", level_db, 4'h1);
    neg(1);
    check_vec("ch0_rise_once", rise_tick, 4'h0);
    neg(3);
    level = 4'h0;
    neg(LAT);
    check_vec("ch0_db_hold", level_db, 4'h1);
    neg(1);
    check_vec("ch0_db_drop", level_db, 4'h0);
    check_vec("ch0_no_fall", fall_tick, 4'h0);
    neg(1);
    check_vec("ch0_no_any", any_tick, 1'b0);

    mode = 8'h0C;
`ifdef EDGE_DEBOUNCE_EN
    track_pulse(1, 3, 12, rk, fk, rn, fn, dbs);
    check_vec("glitch_rise_n", rn, 0);
    check_vec("glitch_fall_n", fn, 0);
    check_vec("glitch_db", dbs, 1'b0);
`endif
    neg(2);
    track_pulse(1, 4, LAT + 8, rk, fk, rn, fn, dbs);
    check_vec("pulse4_rise_k", rk, LAT + 1);
    check_vec("pulse4_fall_k", fk, LAT + 5);
    check_vec("pulse4_rise_n", rn, 1);
    check_vec("pulse4_fall_n", fn, 1);

    mode = 8'hAA; level = 4'hF;
    neg(LAT + 1);
    check_vec("fallmode_no_rise", rise_tick, 4'h0);
    check_vec("fallmode_db_up", level_db, 4'hF);
    neg(3);
    level = 4'h0;
    neg(LAT);
    check_vec("simul_fall_early", fall_tick, 4'h0);
    neg(1);
    check_vec("simul_fall", fall_tick, 4'hF);
    check_vec("simul_tick", tick, 4'hF);
    check_vec("simul_rise", rise_tick, 4'h0);
    check_vec("simul_any_early", any_tick, 1'b0);
    neg(1);
    check_vec("simul_any", any_tick, 1'b1);
    check_vec("simul_fall_once", fall_tick, 4'h0);

    mode = 8'hFF; level = 4'h2;
    neg(LAT + 4);
    level = 4'h3;
    neg((DB > 1) ? 4 : 2);
    check_vec("pend_pre_db", level_db, 4'h2);
    reset_n = 1'b0;
    #1;
    check_vec("async_rst_db", level_db, 4'h0);
    check_vec("async_rst_tick", tick, 4'h0);
    check_vec("async_rst_any", any_tick, 1'b0);
    neg(2);
    reset_n = 1'b1;
    neg(LAT);
    check_vec("rerel_rise_early", rise_tick, 4'h0);
    neg(1);
    check_vec("rerel_rise", rise_tick, 4'h3);
    check_vec("rerel_db", level_db, 4'h3);
    neg(1);
    check_vec("rerel_rise_once", rise_tick, 4'h0);

    level = 4'h0;
    neg(LAT + 4);
    mode = 8'h30;
    track_pulse(2, 1, 8, rk, fk, rn, fn, dbs);
    check_vec("p1_rise_n", rn, (DB == 1) ? 1 : 0);
    check_vec("p1_fall_n", fn, (DB == 1) ? 1 : 0);
    check_vec("p1_rise_k", rk, (DB == 1) ? 3 : 0);
    check_vec("p1_fall_k", fk, (DB == 1) ? 4 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
